// File: rtl/stream_mux_arb_pkg.sv
// stream_mux_pkg: shared types, reset constants and width helper for stream_mux_arb.
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED       = 1'b0,
    MODE_ROUND_ROBIN = 1'b1
  } mode_t;

  // Active level of the synchronous reset and register values it restores.
  localparam logic RST_LEVEL  = 1'b0;
  localparam logic RST_VALID  = 1'b0;
  localparam logic RST_PARITY = 1'b0;

  // Channel index width, never narrower than one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_arb_if.sv
// stream_mux_arb_if: producer/consumer handshake bundle for stream_mux_arb.
// out_parity exists only when STREAM_MUX_PARITY_EN is defined.
interface stream_mux_arb_if
  import stream_mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned CH_W = ch_w(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [CH_W-1:0]           out_chan;
  logic                      out_valid;
  logic                      out_ready;
`ifdef STREAM_MUX_PARITY_EN
  logic                      out_parity;
`endif

`ifdef STREAM_MUX_PARITY_EN
  // Environment side: drives producers and the consumer ready.
  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_chan, out_valid, out_parity);
  // Mux side.
  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_chan, out_valid, out_parity);
`else
  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_chan, out_valid);
  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_chan, out_valid);
`endif

endinterface

// File: rtl/stream_mux_arb_rr_arbiter.sv
// rr_arbiter: round-robin grant over CHANNELS requests, scan starting at ptr.
// ptr moves to one past the granted channel only when advance is asserted.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned CH_W     = ch_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic [CHANNELS-1:0] grant,
  output logic [CH_W-1:0]     ptr
);

  logic [CH_W-1:0] gidx;
  logic            found;
  int unsigned     idx;

  // First requester found scanning ptr, ptr+1, ... modulo CHANNELS.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < CHANNELS; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = CH_W'(idx);
      end
    end
  end

  // Pointer advances past the winner on a committed round-robin transfer.
  always_ff @(posedge clk) begin
    if (rst == RST_LEVEL) begin
      ptr <= '0;
    end else if (advance && found) begin
      if (32'(gidx) == CHANNELS - 1) ptr <= '0;
      else                           ptr <= gidx + 1'b1;
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel valid/ready stream mux with a registered output
// stage, fixed (sel) or round-robin selection.
// Optional macro STREAM_MUX_PARITY_EN adds a registered even-parity bit.
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter  int unsigned WIDTH    = 4,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned CH_W     = ch_w(CHANNELS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [CH_W-1:0] sel,
  stream_mux_arb_if.slave bus
);

  mode_t                mode_q;
  logic [CHANNELS-1:0]  rr_grant;
  logic [CHANNELS-1:0]  fix_grant;
  logic [CHANNELS-1:0]  grant;
  logic [CH_W-1:0]      rr_ptr;
  logic                 can_load;
  logic                 load;
  logic [CH_W-1:0]      tidx;
  logic [WIDTH-1:0]     tdata;

  logic                 valid_q;
  logic [WIDTH-1:0]     data_q;
  logic [CH_W-1:0]      chan_q;

  assign mode_q = mode_t'(mode);

  rr_arbiter #(.CHANNELS(CHANNELS)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.in_valid),
    .advance (load && (mode_q == MODE_ROUND_ROBIN)),
    .grant   (rr_grant),
    .ptr     (rr_ptr)
  );

  // Fixed-mode grant: only the selected channel, nothing for sel >= CHANNELS.
  always_comb begin
    fix_grant = '0;
    for (int unsigned i = 0; i < CHANNELS; i++)
      fix_grant[i] = bus.in_valid[i] && (32'(sel) == i);
  end

  // Ready and load decision; in_ready is held low throughout reset.
  always_comb begin
    grant        = (mode_q == MODE_ROUND_ROBIN) ? rr_grant : fix_grant;
    can_load     = !valid_q || bus.out_ready;
    load         = (rst != RST_LEVEL) && can_load && (|grant);
    bus.in_ready = ((rst != RST_LEVEL) && can_load) ? grant : '0;
  end

  // Steer the granted channel's index and data towards the output register.
  always_comb begin
    tidx  = '0;
    tdata = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        tidx  = CH_W'(i);
        tdata = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register: reload on transfer, empty on pop-only, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst == RST_LEVEL) begin
      valid_q <= RST_VALID;
      data_q  <= '0;
      chan_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= tdata;
      chan_q  <= tidx;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;

`ifdef STREAM_MUX_PARITY_EN
  logic par_q;

  // Parity tracks the data register's load/hold/reset behaviour.
  always_ff @(posedge clk) begin
    if (rst == RST_LEVEL)  par_q <= RST_PARITY;
    else if (load)         par_q <= ^tdata;
  end

  assign bus.out_parity = par_q;
`endif

  // Round-robin pointer must always name a real channel.
  ptr_in_range: assert property (@(posedge clk) 32'(rr_ptr) < CHANNELS);

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: directed stimulus, behavioural model with per-cycle
// comparison, and literal expectations for stream_mux_arb.
module tb_stream_mux_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [1:0] sel;
  logic       mode6;
  logic [2:0] sel6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_mux_arb_if #(.WIDTH(4), .CHANNELS(4)) bus  ();
  stream_mux_arb_if #(.WIDTH(4), .CHANNELS(6)) bus6 ();

  stream_mux_arb #(.WIDTH(4), .CHANNELS(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .sel  (sel),
    .bus  (bus)
  );

  stream_mux_arb #(.WIDTH(4), .CHANNELS(6)) dut6 (
    .clk  (clk),
    .rst  (rst),
    .mode (mode6),
    .sel  (sel6),
    .bus  (bus6)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the 4-channel instance.
  bit         started = 0;
  bit         m_valid = 0;
  logic [3:0] m_data  = '0;
  int         m_chan  = 0;
  int         m_ptr   = 0;

  // Channel that must be accepted this cycle, or -1.
  function automatic int exp_grant();
    if (rst !== 1'b1) return -1;
    if (m_valid && !bus.out_ready) return -1;
    if (mode == 1'b0) return bus.in_valid[sel] ? int'(sel) : -1;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (bus.in_valid[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = exp_grant();
    if (rst === 1'b0) begin
      started = 1;
      m_valid = 0;
      m_data  = '0;
      m_chan  = 0;
      m_ptr   = 0;
    end else if (g >= 0) begin
      m_valid = 1;
      m_data  = bus.in_data[g*4 +: 4];
      m_chan  = g;
      if (mode == 1'b1) m_ptr = (g + 1) % 4;
    end else if (bus.out_ready) begin
      m_valid = 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      int g;
      logic [3:0] rdy;
      g   = exp_grant();
      rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      check("cyc_valid", int'(bus.out_valid), int'(m_valid));
      check("cyc_data",  int'(bus.out_data),  int'(m_data));
      check("cyc_chan",  int'(bus.out_chan),  m_chan);
      check("cyc_ready", int'(bus.in_ready),  int'(rdy));
`ifdef STREAM_MUX_PARITY_EN
      check("cyc_parity", int'(bus.out_parity), int'(^m_data));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int fair[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int skip[4] = '{1, 3, 1, 3};

  initial begin
    rst           = 1'b0;
    mode          = 1'b1;
    sel           = '0;
    bus.in_valid  = 4'hF;
    bus.in_data   = 16'h4321;
    bus.out_ready = 1'b1;
    mode6          = 1'b0;
    sel6           = '0;
    bus6.in_valid  = '0;
    bus6.in_data   = '0;
    bus6.out_ready = 1'b1;

    // Reset with every channel requesting.
    repeat (3) step();
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_data",  int'(bus.out_data),  0);
    check("rst_ready", int'(bus.in_ready),  0);

    // Release in round-robin: scan starts at channel 0.
    rst = 1'b1;
    #1;
    check("post_rst_ready", int'(bus.in_ready), 4'b0001);
    foreach (fair[i]) begin
      step();
      check("rr_fair_chan",  int'(bus.out_chan),  fair[i]);
      check("rr_fair_data",  int'(bus.out_data),  fair[i] + 1);
      check("rr_fair_valid", int'(bus.out_valid), 1);
    end

    // Only channels 1 and 3: skip empty channels and wrap 3 -> 0 -> 1.
    bus.in_valid = 4'b1010;
    bus.in_data  = 16'h8765;
    foreach (skip[i]) begin
      step();
      check("rr_skip_chan", int'(bus.out_chan), skip[i]);
    end

    // Fixed mode, sel=2 with channels 0 and 2 valid.
    mode         = 1'b0;
    sel          = 2'd2;
    bus.in_data  = 16'h0A05;
    bus.in_valid = 4'b0101;
    #1;
    check("fix_ready", int'(bus.in_ready), 4'b0100);
    step();
    check("fix_data", int'(bus.out_data), 4'b1010);
    check("fix_chan", int'(bus.out_chan), 2);

    // Backpressure: hold 4'hC for 4 cycles, then pop and reload together.
    sel          = 2'd1;
    bus.in_data  = 16'h00C0;
    bus.in_valid = 4'b0010;
    step();
    check("bp_load", int'(bus.out_data), 4'hC);
    bus.out_ready = 1'b0;
    bus.in_data   = 16'h0030;
    repeat (4) begin
      step();
      check("bp_hold_data",  int'(bus.out_data),  4'hC);
      check("bp_hold_valid", int'(bus.out_valid), 1);
      check("bp_hold_ready", int'(bus.in_ready),  0);
    end
    bus.out_ready = 1'b1;
    bus.in_data   = 16'h0090;
    #1;
    check("bp_release_ready", int'(bus.in_ready), 4'b0010);
    step();
    check("bp_reload_valid", int'(bus.out_valid), 1);
    check("bp_reload_data",  int'(bus.out_data),  4'h9);

`ifdef STREAM_MUX_PARITY_EN
    bus.in_data = 16'h0070;
    step();
    check("parity_odd", int'(bus.out_parity), 1);
    bus.in_data = 16'h0060;
    step();
    check("parity_even", int'(bus.out_parity), 0);
`endif

    // Mid-transfer reset after a round-robin grant has moved ptr to 3.
    mode         = 1'b1;
    bus.in_valid = 4'b0100;
    bus.in_data  = 16'h0D00;
    step();
    check("pre_rst_chan", int'(bus.out_chan), 2);
    bus.out_ready = 1'b0;
    rst           = 1'b0;
    step();
    check("mid_rst_valid", int'(bus.out_valid), 0);
    check("mid_rst_data",  int'(bus.out_data),  0);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'hF;
    bus.in_data   = 16'h4321;
    step();
    check("post_mid_rst_chan", int'(bus.out_chan), 0);

    // Six-channel instance: sel=5 is a real channel, sel=6 grants nothing.
    sel6          = 3'd5;
    bus6.in_valid = 6'b100000;
    bus6.in_data  = 24'hE00000;
    step();
    check("ch6_chan",  int'(bus6.out_chan),  5);
    check("ch6_data",  int'(bus6.out_data),  4'hE);
    check("ch6_valid", int'(bus6.out_valid), 1);
    sel6          = 3'd6;
    bus6.in_valid = 6'b111111;
    #1;
    check("ch6_sel_oob_ready", int'(bus6.in_ready), 0);

    // Idle drain: no requests, output empties.
    bus.in_valid = '0;
    repeat (3) step();
    check("drain_valid", int'(bus.out_valid), 0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_arb.md
# stream_mux_arb

Parametrised N-channel, WIDTH-bit streaming multiplexer with valid/ready handshakes on every input and on the output, a registered output stage and two selection modes: fixed (external select) and round-robin. It generalises the team's combinational 2:1 4-bit mux into a buffered, flow-controlled datapath element. It sits between several producer streams and a single consumer.

## Interface
- WIDTH, 4, data width per channel (>=1)
- CHANNELS, 4, number of input channels (2..16)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  per-channel valid
- in_ready  out  CHANNELS  per-channel ready (combinational)
- mode  in  1  0 = FIXED, 1 = ROUND_ROBIN
- sel  in  CH_W  channel index used in FIXED mode; CH_W = max(1, $clog2(CHANNELS))
- out_data  out  WIDTH  registered output word
- out_chan  out  CH_W  index of the channel that supplied out_data
- out_valid  out  1  output word valid
- out_ready  in  1  consumer ready
- out_parity  out  1  even parity of out_data (only with STREAM_MUX_PARITY_EN)

## Operation
- Output register has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_load = !out_valid || out_ready.
- Grant, combinational, at most one bit set:
  - FIXED: grant[sel] = in_valid[sel]. sel >= CHANNELS grants nothing.
  - ROUND_ROBIN: grant goes to the first i with in_valid[i], scanning ptr, ptr+1, … modulo CHANNELS.
- in_ready[i] = grant[i] && can_load. A transfer occurs when in_valid[i] && in_ready[i].
- On a transfer: out_data <= channel data, out_chan <= i, out_valid <= 1. In ROUND_ROBIN mode, ptr <= (i+1) mod CHANNELS, with wrap from CHANNELS-1 to 0.
- Output handshake with no input transfer: out_valid <= 0.
- Simultaneous output pop and input transfer: the register reloads in the same cycle, out_valid stays 1, and there is no bubble.
- FULL && !out_ready: out_data, out_chan and out_valid hold, and all in_ready are 0.
- ptr changes only on a ROUND_ROBIN transfer. It is retained across FIXED periods.
- A change of mode or sel takes effect at the next arbitration. It never alters a word already held in the register.
- No valid inputs: no grant, ptr unchanged.

## Timing
- Latency: an input accepted at edge k is visible at the outputs after edge k, giving 1 cycle.
- Throughput: 1 word per cycle when out_ready is held at 1.
- in_ready depends combinationally on in_valid, mode, sel, ptr, out_valid and out_ready. There is no combinational path from in_data to any output.
- Reset (rst=0 at an edge):
  - out_valid=0, out_data=0, out_chan=0, ptr=0, out_parity=0.
  - in_ready is forced to 0 while rst=0.
- Reset mid-transfer discards the held word. The first post-reset round-robin grant starts the scan at channel 0.

## Configuration
- STREAM_MUX_PARITY_EN defined:
  - out_parity port exists.
  - A parity bit (^in_data slice) is registered alongside out_data and follows the same load, hold and reset rules.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- Shared package stream_mux_pkg holds:
  - mode_t enum {MODE_FIXED=1'b0, MODE_ROUND_ROBIN=1'b1}
  - function ch_w(n) returning max(1, $clog2(n))
  - reset constants
- Sub-module rr_arbiter holds the round-robin logic:
  - Parameter CHANNELS.
  - Inputs: req, advance, clk, rst.
  - Outputs: one-hot grant and pointer register.
- The top level instantiates rr_arbiter and adds the fixed-mode path, the ready logic and the output register.

## Test plan
- Reset check: hold rst=0 for 3 cycles with all in_valid=1 -> out_valid=0, out_data=0, all in_ready=0. After release with mode=1, the first word comes from channel 0.
- FIXED mode: WIDTH=4, CHANNELS=4, mode=0, sel=2, ch2=4'b1010, ch0=4'b0101 valid, out_ready=1 -> only in_ready[2]=1. Next cycle out_data=1010, out_chan=2. Then sel=5 with CHANNELS=6 -> out_chan=5 on the next transfer.
- Round-robin fairness: mode=1, all four channels valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1 at one word per cycle.
- Round-robin skip and wrap: only ch1 and ch3 valid -> out_chan sequence 1,3,1,3. ptr wraps 3->0 and the scan lands on 1.
- Backpressure: FULL with out_data=4'hC and out_ready=0 for 4 cycles -> out_data stays C, all in_ready=0. Raising out_ready with ch1 valid -> pop and reload in the same cycle, out_valid stays 1.
- Parity (STREAM_MUX_PARITY_EN): load 4'b0111 -> out_parity=1; load 4'b0110 -> out_parity=0. Without the macro, the bench compiles without out_parity.
